// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: upstream driver for a bank of NUM_DIGITS seven-segment decoders.
// Captures a hex value on a load strobe. Generates per-digit data, blank and test
// signals with leading-zero blanking, whole-display blink and a timed lamp test.
// All outputs are registered.
//
// Ports:
//   clk          system clock, rising edge
//   reset_n      synchronous active-low reset
//   load         one-cycle strobe, captures value
//   value        hex value, digit i = value[4i+3:4i], digit 0 least significant
//   lz_en        enable leading-zero blanking
//   blink_en     enable blinking of the whole display
//   test_req     start a lamp test (level or pulse)
//   digit_data   per-digit 4-bit data to the decoders
//   digit_blank  per-digit blank
//   digit_test   per-digit lamp test
//   test_active  high while the lamp test runs
module hex_display_ctrl #(
   parameter int unsigned NUM_DIGITS  = 4,
   parameter int unsigned BLINK_DIV   = 25000000,
   parameter int unsigned TEST_CYCLES = 50000000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    lz_en,
   input  logic                    blink_en,
   input  logic                    test_req,
   output logic [4*NUM_DIGITS-1:0] digit_data,
   output logic [NUM_DIGITS-1:0]   digit_blank,
   output logic [NUM_DIGITS-1:0]   digit_test,
   output logic                    test_active
);

   localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam int unsigned TestW  = (TEST_CYCLES > 1) ? $clog2(TEST_CYCLES) : 1;
   localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_DIV - 1);
   localparam logic [TestW-1:0]  TestMax  = TestW'(TEST_CYCLES - 1);

   localparam logic [0:0] StIdle = 1'b0;
   localparam logic [0:0] StTest = 1'b1;

   logic [4*NUM_DIGITS-1:0] value_q, value_d;
   logic                    valid_q, valid_d;
   logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
   logic                    blink_phase_q, blink_phase_d;
   logic [0:0]              state_q, state_d;
   logic [TestW-1:0]        test_cnt_q, test_cnt_d;
   logic [4*NUM_DIGITS-1:0] digit_data_q, digit_data_d;
   logic [NUM_DIGITS-1:0]   digit_blank_q, digit_blank_d;
   logic [NUM_DIGITS-1:0]   digit_test_q, digit_test_d;
   logic [NUM_DIGITS-1:0]   lz_mask;
   logic                    higher_zero;

   // Value capture
   always_comb begin
      value_d = value_q;
      valid_d = valid_q;
      if (load) begin
         value_d = value;
         valid_d = 1'b1;
      end
   end

   // Blink divider
   always_comb begin
      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (!blink_en) begin
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (blink_cnt_q == BlinkMax) begin
         blink_cnt_d   = '0;
         blink_phase_d = ~blink_phase_q;
      end else begin
         blink_cnt_d = blink_cnt_q + 1'b1;
      end
   end

   // Lamp test FSM; no retrigger while in StTest
   always_comb begin
      state_d    = state_q;
      test_cnt_d = test_cnt_q;
      case (state_q)
         StIdle: begin
            if (test_req) begin
               state_d    = StTest;
               test_cnt_d = '0;
            end
         end
         StTest: begin
            if (test_cnt_q == TestMax) begin
               state_d = StIdle;
            end else begin
               test_cnt_d = test_cnt_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Digit i (i >= 1) blanks when it and all higher digits are zero; digit 0 never does
   always_comb begin
      lz_mask     = '0;
      higher_zero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         higher_zero = higher_zero & (value_q[4*i +: 4] == 4'h0);
         lz_mask[i]  = higher_zero;
      end
   end

   // Output next-state. Test is decoded from the next FSM state so the lamp test
   // appears the cycle right after test_req is sampled; blank wins over test in
   // the decoder, so blank is forced low during the test.
   always_comb begin
      digit_data_d = value_q;
      if (state_d == StTest) begin
         digit_blank_d = '0;
         digit_test_d  = '1;
      end else begin
         digit_blank_d = {NUM_DIGITS{~valid_q}} | {NUM_DIGITS{blink_phase_d}} |
                         (lz_en ? lz_mask : '0);
         digit_test_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         value_q       <= '0;
         valid_q       <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         state_q       <= StIdle;
         test_cnt_q    <= '0;
         digit_data_q  <= '0;
         digit_blank_q <= '1;
         digit_test_q  <= '0;
      end else begin
         value_q       <= value_d;
         valid_q       <= valid_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         state_q       <= state_d;
         test_cnt_q    <= test_cnt_d;
         digit_data_q  <= digit_data_d;
         digit_blank_q <= digit_blank_d;
         digit_test_q  <= digit_test_d;
      end
   end

   assign digit_data  = digit_data_q;
   assign digit_blank = digit_blank_q;
   assign digit_test  = digit_test_q;
   assign test_active = (state_q == StTest);

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Self-checking bench for hex_display_ctrl with a queue-based scoreboard.
module tb_hex_display_ctrl;

   localparam int N  = 4;
   localparam int BD = 4;
   localparam int TC = 8;

   logic        clk = 1'b0;
   logic        reset_n, load, lz_en, blink_en, test_req;
   logic [15:0] value;
   logic [15:0] digit_data;
   logic [3:0]  digit_blank, digit_test;
   logic        test_active;

   always #5 clk = ~clk;

   hex_display_ctrl #(
      .NUM_DIGITS (N),
      .BLINK_DIV  (BD),
      .TEST_CYCLES(TC)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (load),
      .value      (value),
      .lz_en      (lz_en),
      .blink_en   (blink_en),
      .test_req   (test_req),
      .digit_data (digit_data),
      .digit_blank(digit_blank),
      .digit_test (digit_test),
      .test_active(test_active)
   );

   typedef struct packed {
      logic [15:0] data;
      logic [3:0]  blank;
      logic [3:0]  test;
      logic        active;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference model state
   logic [15:0] m_val;
   bit          m_valid;
   int          m_run;   // consecutive edges with blink enabled
   int          m_rem;   // lamp-test cycles remaining, including the current one

   // Blank every digit above the most significant nonzero one
   function automatic logic [3:0] lz_mask_f(logic [15:0] v);
      int          msd;
      logic [3:0]  m;
      msd = 0;
      for (int i = 0; i < N; i++) if (v[4*i +: 4] != 4'h0) msd = i;
      for (int i = 0; i < N; i++) m[i] = (i > msd);
      return m;
   endfunction

   task automatic tick();
      exp_t e;
      bit   phase;
      @(posedge clk);
      if (!reset_n) begin
         e       = '{data: 16'h0, blank: 4'hF, test: 4'h0, active: 1'b0};
         m_val   = 16'h0;
         m_valid = 1'b0;
         m_run   = 0;
         m_rem   = 0;
      end else begin
         if (m_rem > 0) m_rem--;
         else if (test_req) m_rem = TC;
         m_run  = blink_en ? m_run + 1 : 0;
         phase  = ((m_run / BD) % 2) == 1;
         e.data = m_val;
         if (m_rem > 0) begin
            e.blank  = 4'h0;
            e.test   = 4'hF;
            e.active = 1'b1;
         end else begin
            e.blank  = (!m_valid || phase) ? 4'hF : (lz_en ? lz_mask_f(m_val) : 4'h0);
            e.test   = 4'h0;
            e.active = 1'b0;
         end
         if (load) begin
            m_val   = value;
            m_valid = 1'b1;
         end
      end
      exp_q.push_back(e);
      #1;
   endtask

   task automatic chk(string name, logic [15:0] act, logic [15:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: one registered output set per cycle
   always @(negedge clk) begin : monitor
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("digit_data", digit_data, e.data);
         chk("digit_blank", {12'h0, digit_blank}, {12'h0, e.blank});
         chk("digit_test", {12'h0, digit_test}, {12'h0, e.test});
         chk("test_active", {15'h0, test_active}, {15'h0, e.active});
      end
   end

   task automatic do_load(logic [15:0] v, int settle);
      value = v;
      load  = 1'b1;
      tick();
      load = 1'b0;
      repeat (settle) tick();
   endtask

   initial begin
      logic [15:0] lz_vals [4];
      lz_vals = '{16'h00A3, 16'h0000, 16'h0100, 16'h1003};
      reset_n = 1'b0; load = 1'b0; value = '0;
      lz_en = 1'b0; blink_en = 1'b0; test_req = 1'b0;
      repeat (2) tick();
      reset_n = 1'b1;
      repeat (3) tick();

      // Basic load, no suppression
      do_load(16'h12AF, 3);

      // Leading-zero blanking
      lz_en = 1'b1;
      foreach (lz_vals[k]) do_load(lz_vals[k], 3);
      lz_en = 1'b0;

      // Blink, then drop blink_en during phase 1
      do_load(16'h5555, 2);
      blink_en = 1'b1;
      repeat (13) tick();
      blink_en = 1'b0;
      repeat (3) tick();

      // Lamp test with valid = 0, retrigger attempt mid-test
      reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
      test_req = 1'b1; tick(); test_req = 1'b0;
      repeat (2) tick();
      test_req = 1'b1; tick(); test_req = 1'b0;
      repeat (8) tick();

      // Held test_req: back-to-back tests
      test_req = 1'b1; repeat (20) tick(); test_req = 1'b0;
      repeat (10) tick();

      // Load during a test
      test_req = 1'b1; tick(); test_req = 1'b0; tick();
      do_load(16'hBEEF, 10);

      // Reset mid-test with blink on; load in the reset cycle is ignored
      blink_en = 1'b1;
      test_req = 1'b1; tick(); test_req = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0; load = 1'b1; value = 16'h1234; tick();
      reset_n = 1'b1; load = 1'b0;
      repeat (4) tick();

      // Randomised traffic
      repeat (600) begin
         reset_n  = ($urandom_range(0, 149) != 0);
         load     = ($urandom_range(0, 3) == 0);
         value    = 16'($urandom) & (16'hFFFF >> (4 * $urandom_range(0, 4)));
         lz_en    = 1'($urandom);
         blink_en = ($urandom_range(0, 9) != 0);
         test_req = ($urandom_range(0, 14) == 0);
         tick();
      end
      reset_n = 1'b1; load = 1'b0; test_req = 1'b0; blink_en = 1'b0;
      repeat (2) tick();

      @(negedge clk);
      #1;
      chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hex_display_ctrl.md
Name: hex_display_ctrl

Overview:
- Upstream driver for a bank of NUM_DIGITS seven-segment decoders.
- Captures a hex value on a load strobe and holds it between updates.
- Generates each digit's 4-bit data, blank and test inputs with leading-zero blanking, a blink mode and a timed lamp test.
- All outputs are registered and feed the per-digit decoders directly.

Parameters:
- NUM_DIGITS, 4, number of hex digits driven; must be >= 1.
- BLINK_DIV, 25000000, clk cycles per blink half-period; must be >= 1.
- TEST_CYCLES, 50000000, clk cycles the lamp test stays asserted; must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- load  input  1  one-cycle strobe; capture value.
- value  input  4*NUM_DIGITS  hex value; digit i = value[4i+3:4i], digit 0 = least significant.
- lz_en  input  1  enable leading-zero blanking.
- blink_en  input  1  enable blinking of the whole display.
- test_req  input  1  start a lamp test (level or pulse).
- digit_data  output  4*NUM_DIGITS  per-digit data to the decoders.
- digit_blank  output  NUM_DIGITS  per-digit blank.
- digit_test  output  NUM_DIGITS  per-digit test.
- test_active  output  1  high while the lamp test runs.

Behaviour:
- Reset (reset_n low at a rising edge):
  - value register = 0, valid = 0, blink counter = 0, blink phase = 0, FSM = IDLE.
  - Outputs: digit_data = 0, digit_blank = all 1s, digit_test = 0, test_active = 0.
  - Reset has priority over load and test_req in the same cycle.
  - Reset asserted mid-test aborts the test immediately.
- Load:
  - When load = 1 at an edge, the value register takes value and valid is set to 1.
  - Outputs reflect the new value on the next edge (2-cycle latency from load to the decoder inputs, because outputs are registered).
  - Load is accepted in every state, including TEST. During TEST the new value is shown once the test ends.
- valid = 0: all digits are blanked regardless of lz_en and blink_en. Lamp test still works.
- Leading-zero blanking (lz_en = 1):
  - Digit i (i >= 1) is blanked iff digit i and every higher digit equal 0.
  - Digit 0 is never blanked by this rule, so value 0 displays a single "0".
  - lz_en = 0: no zero suppression.
- Blink:
  - The counter runs whenever blink_en = 1. It counts 0..BLINK_DIV-1, then wraps to 0 and toggles the phase.
  - blink_en = 0 clears the counter and the phase on the next edge.
  - Phase = 1 forces all digit_blank bits to 1.
- Lamp test FSM, states IDLE and TEST:
  - IDLE -> TEST when test_req = 1; the counter is loaded with 0.
  - TEST: the counter increments each cycle. At count TEST_CYCLES-1 the FSM returns to IDLE on the next edge.
  - test_req while in TEST is ignored, with no retrigger.
  - A held test_req re-enters TEST the cycle after returning to IDLE.
  - digit_test and test_active are all 1 for exactly TEST_CYCLES consecutive cycles, starting the cycle after the test_req edge.
- Priority, because the decoder gives blank priority over test:
  - In TEST, digit_blank is forced to all 0s and digit_test to all 1s, overriding valid, blink and leading-zero blanking.
  - Outside TEST: digit_test = 0 and digit_blank = (~valid) | blink_phase | lz_mask.
- digit_data always equals the value register (registered copy), including during TEST and blanking.
- No arithmetic beyond the counters. Counter widths are $clog2 of their limit, with a minimum of 1 bit.

Test Plan (bench uses NUM_DIGITS=4, BLINK_DIV=4, TEST_CYCLES=8):
1. Reset released, no load -> digit_blank = 4'b1111, digit_test = 0, digit_data = 0, test_active = 0. Then load value = 16'h12AF, lz_en = 0 -> 2 cycles later digit_data = 16'h12AF, digit_blank = 4'b0000.
2. lz_en = 1 with loads 16'h00A3, 16'h0000, 16'h0100 -> digit_blank = 4'b1100, 4'b1110, 4'b1000 respectively. A mid-zero digit (16'h1003) -> digit_blank = 4'b0000.
3. blink_en = 1 after loading 16'h5555 -> digit_blank alternates 4'b0000 and 4'b1111 every 4 cycles. Dropping blink_en during phase 1 -> 4'b0000 on the next edge.
4. One-cycle test_req pulse while valid = 0 -> digit_test = 4'b1111, digit_blank = 4'b0000, test_active = 1 for exactly 8 cycles, then back to all-blank.
   - A second test_req at cycle 3 of the test does not extend it.
   - A held test_req gives back-to-back 8-cycle tests.
5. Load 16'hBEEF during a test -> digit_data updates within 2 cycles, but digit_test stays 1 until the 8 cycles elapse. The display then shows BEEF unblanked.
6. reset_n low at cycle 4 of a test with blink_en = 1 -> next edge: test_active = 0, digit_blank = 4'b1111, value register = 0, blink phase = 0.
   - load = 1 in the same cycle as reset_n low is ignored, so valid stays 0.
